// File: rtl/instr_feeder.sv
// instr_feeder: buffers an 8-bit program and replays it as load-strobed instructions.
// Define FEEDER_LOOP_EN to repeat the program until aborted instead of a single pass.
module instr_feeder #(
  parameter int DEPTH = 16,
  parameter int AW    = 4,
  parameter int GAP   = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wr_en,
  input  logic [7:0]  wr_data,
  input  logic        start,
  input  logic        abort,
  output logic [7:0]  instr,
  output logic        load,
  output logic        state,
  output logic        busy,
  output logic        done,
  output logic [AW:0] count,
  output logic        overflow
);
  localparam int GW = (GAP > 1) ? $clog2(GAP) : 1;
  localparam logic [AW:0]   FULL     = (AW + 1)'(DEPTH);
  localparam logic [GW-1:0] GAP_LAST = GW'(GAP - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, FIN} fsm_t;

  fsm_t          fsm_reg, fsm_next;
  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wptr_reg, rptr_reg;
  logic [AW:0]   count_reg, count_upd;
  logic [GW-1:0] gap_reg;
  logic [7:0]    instr_reg;
  logic          overflow_reg, load_reg, run_reg, done_reg;
  logic          load_next, run_next, done_next;
  logic          idle, wr_ok, wr_drop, clear, last, gap_zero;

  assign idle      = (fsm_reg == IDLE);
  assign wr_ok     = idle && wr_en && (count_reg < FULL);
  assign wr_drop   = idle && wr_en && (count_reg == FULL);
  assign clear     = idle && start && abort;
  // A write in the start cycle lands first, so start sees the updated count.
  assign count_upd = count_reg + (AW + 1)'(wr_ok);
  assign last      = ({1'b0, rptr_reg} == (count_reg - (AW + 1)'(1)));
  assign gap_zero  = (gap_reg == '0);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) fsm_reg <= IDLE;
    else      fsm_reg <= fsm_next;
  end

  always_comb begin
    fsm_next = fsm_reg;
    case (fsm_reg)
      IDLE:  if (start && !abort) fsm_next = (count_upd != '0) ? ISSUE : FIN;
      ISSUE: fsm_next = abort ? FIN : WAIT;
      WAIT: begin
        if (abort) fsm_next = FIN;
        else if (gap_zero) begin
`ifdef FEEDER_LOOP_EN
          fsm_next = ISSUE;
`else
          fsm_next = last ? FIN : ISSUE;
`endif
        end
      end
      FIN:     fsm_next = IDLE;
      default: fsm_next = IDLE;
    endcase
  end

  always_comb begin
    load_next = (fsm_reg == ISSUE);
    run_next  = (fsm_reg == ISSUE) || (fsm_reg == WAIT);
    done_next = (fsm_reg == FIN);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_reg    <= '0;
      wptr_reg     <= '0;
      rptr_reg     <= '0;
      gap_reg      <= '0;
      overflow_reg <= 1'b0;
      instr_reg    <= 8'h00;
      load_reg     <= 1'b0;
      run_reg      <= 1'b0;
      done_reg     <= 1'b0;
    end else begin
      if (clear) begin
        count_reg    <= '0;
        wptr_reg     <= '0;
        overflow_reg <= 1'b0;
      end else begin
        if (wr_ok) begin
          count_reg <= count_upd;
          wptr_reg  <= wptr_reg + AW'(1);
        end
        if (wr_drop) overflow_reg <= 1'b1;
      end

      if (idle && fsm_next == ISSUE)
        rptr_reg <= '0;
      else if (fsm_reg == WAIT && fsm_next == ISSUE)
        rptr_reg <= last ? '0 : rptr_reg + AW'(1);

      if (fsm_reg == ISSUE)
        gap_reg <= GAP_LAST;
      else if (fsm_reg == WAIT && !gap_zero)
        gap_reg <= gap_reg - GW'(1);

      // Registered read: the instruction appears together with its load strobe.
      if (fsm_reg == ISSUE) instr_reg <= mem[rptr_reg];
      load_reg <= load_next;
      run_reg  <= run_next;
      done_reg <= done_next;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_ok) mem[wptr_reg] <= wr_data;
  end

  assign instr    = instr_reg;
  assign load     = load_reg;
  assign state    = run_reg;
  assign busy     = run_reg;
  assign done     = done_reg;
  assign count    = count_reg;
  assign overflow = overflow_reg;
endmodule

// File: doc/instr_feeder.md
Name: instr_feeder

Overview:
- Upstream instruction-supply stage for the 4-bit microcode processor top.
- Buffers a program of 8-bit instructions written by a host/testbench.
- On start, replays the program to the processor's instr/load/state inputs, one instruction per issue slot.
- Spaces issue slots by a fixed gap so the microcode sequencer can finish each instruction.

Parameters:
- DEPTH, 16, number of instruction slots in the program buffer (power of 2).
- AW, 4, address width, log2(DEPTH).
- GAP, 4, idle cycles between consecutive load pulses (minimum 1).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  reset; asynchronous and active-low.
- wr_en  input  1  program write strobe; one instruction per cycle.
- wr_data  input  8  instruction to write.
- start  input  1  single-cycle pulse that begins program replay.
- abort  input  1  stops replay at the next cycle boundary.
- instr  output  8  instruction to the processor.
- load  output  1  one-cycle strobe; instr is valid in the same cycle.
- state  output  1  processor run/load mode: 1 while replaying, 0 otherwise.
- busy  output  1  high in ISSUE or WAIT.
- done  output  1  one-cycle pulse when replay completes or is aborted.
- count  output  AW+1  number of instructions currently stored.
- overflow  output  1  sticky; set when a write is dropped because the buffer is full.

Behaviour:
- Reset (rst=0, asynchronous): state machine goes to IDLE, count=0, write pointer=0, read pointer=0, gap counter=0. Outputs are instr=8'h00, load=0, state=0, busy=0, done=0, overflow=0. Buffer contents are not reset.
- Reset asserted mid-replay: takes effect immediately. A load pulse in flight is dropped and no done pulse is produced.
- States: IDLE, ISSUE, WAIT, FIN.
- IDLE, writes:
  - wr_en=1 with count<DEPTH: write mem[wptr], increment wptr and count next edge.
  - wr_en=1 with count==DEPTH: data dropped, overflow set.
  - Writes in any other state are ignored and do not set overflow.
- IDLE, start:
  - start=1 with count>0: go to ISSUE, set rptr=0.
  - start=1 with count==0: go to FIN.
  - start and wr_en in the same cycle: the write is performed first, then start uses the updated count.
- ISSUE (1 cycle):
  - instr=mem[rptr], load=1, state=1, busy=1.
  - Go to WAIT with gap counter = GAP-1.
- WAIT:
  - load=0; instr holds its last value; state=1, busy=1.
  - Gap counter decrements each cycle.
  - At 0: if rptr==count-1, go to FIN; otherwise rptr+1 and go to ISSUE.
  - Spacing: load pulses are exactly GAP+1 cycles apart.
- FIN (1 cycle): done=1, state=0, busy=0, then IDLE. Buffer and count are preserved, so start may replay the same program.
- abort:
  - abort=1 in ISSUE or WAIT goes to FIN next edge.
  - A load asserted in the abort cycle still completes, since it is a registered output.
  - abort in IDLE or FIN has no effect.
- Clearing the program: a start pulse while abort=1 in IDLE sets count=0, wptr=0 and overflow=0, and does not enter replay.
- All outputs are registered; instr/load change only on rising clk edges.
- Latency: start sampled at edge N gives load=1 after edge N+1.

Optional Feature:
- Macro FEEDER_LOOP_EN.
- Defined: at the end of WAIT with rptr==count-1, rptr wraps to 0 and the FSM returns to ISSUE, repeating the program indefinitely. FIN is reached only via abort.
- Undefined: single pass, then FIN as above.

Test Plan:
- Write 8'hA1, 8'hB2, 8'hC3 with GAP=4, then pulse start:
  - count=3;
  - load pulses carry A1, B2, C3, exactly 5 cycles apart;
  - state=1 from the first ISSUE until FIN;
  - done pulses once, 5 cycles after the C3 load.
- Write 17 instructions with DEPTH=16: count=16, overflow=1 after the 17th write; replay issues the first 16 only.
- Pulse start with count=0: done pulses 1 cycle later, load never asserts, state stays 0.
- Start a 5-instruction program, assert abort during WAIT after the 2nd load: no further load, done pulses next cycle; a second start replays from instruction 0.
- Drive rst low during WAIT of a 4-instruction replay: load=0, state=0, busy=0, count=0 at once; no done pulse after rst returns high.
- With FEEDER_LOOP_EN defined, program 8'h11, 8'h22 and pulse start: load sequence is 11, 22, 11, 22, ... until abort, then one done pulse.
